// File: rtl/cve2_wb_arbiter_pkg.sv
// Shared writeback definitions: result-source encoding and register-index width.
package cve2_pkg;

   typedef enum logic [2:0] {
      WB_NONE,
      WB_EX,
      WB_LSU_BUF,
      WB_LSU,
      WB_XIF
   } wb_src_e;

   function automatic int unsigned addr_width(input bit rv32e);
      return rv32e ? 32'd4 : 32'd5;
   endfunction

endpackage

// File: rtl/cve2_wb_arbiter_if.sv
// Writeback arbiter bus: result sources, scoreboard/decode checks and RF write port.
interface cve2_wb_arbiter_if #(
   parameter int unsigned DataWidth = 32
) ();

   logic                 ex_we_i;
   logic [4:0]           ex_waddr_i;
   logic [DataWidth-1:0] ex_wdata_i;
   logic                 lsu_we_i;
   logic [4:0]           lsu_waddr_i;
   logic [DataWidth-1:0] lsu_wdata_i;
   logic                 lsu_ready_o;
   logic                 xif_valid_i;
   logic [4:0]           xif_waddr_i;
   logic [DataWidth-1:0] xif_wdata_i;
   logic                 xif_ready_o;
   logic                 sb_set_i;
   logic [4:0]           sb_set_addr_i;
   logic [4:0]           raddr_a_i;
   logic [4:0]           raddr_b_i;
   logic [4:0]           raddr_c_i;
   logic                 hazard_o;
   logic [4:0]           waddr_o;
   logic [DataWidth-1:0] wdata_o;
   logic                 we_o;

   modport slave (
      input  ex_we_i, ex_waddr_i, ex_wdata_i,
      input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
      output lsu_ready_o,
      input  xif_valid_i, xif_waddr_i, xif_wdata_i,
      output xif_ready_o,
      input  sb_set_i, sb_set_addr_i,
      input  raddr_a_i, raddr_b_i, raddr_c_i,
      output hazard_o,
      output waddr_o, wdata_o, we_o
   );

   modport master (
      output ex_we_i, ex_waddr_i, ex_wdata_i,
      output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
      input  lsu_ready_o,
      output xif_valid_i, xif_waddr_i, xif_wdata_i,
      input  xif_ready_o,
      output sb_set_i, sb_set_addr_i,
      output raddr_a_i, raddr_b_i, raddr_c_i,
      input  hazard_o,
      input  waddr_o, wdata_o, we_o
   );

endinterface

// File: rtl/cve2_wb_scoreboard.sv
// Pending-write bits for LSU/XIF destinations and the decode read-hazard check.
module cve2_wb_scoreboard #(
   parameter int unsigned AW         = 5,
   parameter bit          XInterface = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          set_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   input  logic [AW-1:0] raddr_c_i,
   output logic          hazard_o
);

   localparam int unsigned NREG = 1 << AW;

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   // Set is applied after clear so a re-issue in the commit cycle stays pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (clr_i) w_busy_nxt[clr_addr_i] = 1'b0;
      if (set_i) w_busy_nxt[set_addr_i] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_busy <= '0;
      else         r_busy <= w_busy_nxt;
   end

   assign hazard_o = r_busy[raddr_a_i] | r_busy[raddr_b_i] | (XInterface & r_busy[raddr_c_i]);

endmodule

// File: rtl/cve2_wb_arbiter.sv
// Writeback arbiter: merges EX, buffered LSU and XIF results onto the registered RF write port.
module cve2_wb_arbiter
   import cve2_pkg::*;
#(
   parameter int unsigned RV32E      = 0,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned XInterface = 0
) (
   input logic             clk_i,
   input logic             rst_ni,
   cve2_wb_arbiter_if.slave bus
);

   localparam int unsigned AW = addr_width(RV32E != 0);

   logic                 r_buf_valid;
   logic [AW-1:0]        r_buf_addr;
   logic [DataWidth-1:0] r_buf_data;
   logic                 r_we;
   logic [4:0]           r_waddr;
   logic [DataWidth-1:0] r_wdata;

   wb_src_e              w_sel;
   logic [AW-1:0]        w_sel_addr;
   logic [DataWidth-1:0] w_sel_data;
   logic                 w_xif_ready;

   assign w_xif_ready = (XInterface != 0) && !bus.ex_we_i && !r_buf_valid && !bus.lsu_we_i;

   always_comb begin
      w_sel      = WB_NONE;
      w_sel_addr = '0;
      w_sel_data = '0;
      if (bus.ex_we_i) begin
         w_sel      = WB_EX;
         w_sel_addr = bus.ex_waddr_i[AW-1:0];
         w_sel_data = bus.ex_wdata_i;
      end else if (r_buf_valid) begin
         w_sel      = WB_LSU_BUF;
         w_sel_addr = r_buf_addr;
         w_sel_data = r_buf_data;
      end else if (bus.lsu_we_i) begin
         w_sel      = WB_LSU;
         w_sel_addr = bus.lsu_waddr_i[AW-1:0];
         w_sel_data = bus.lsu_wdata_i;
      end else if (bus.xif_valid_i && w_xif_ready) begin
         w_sel      = WB_XIF;
         w_sel_addr = bus.xif_waddr_i[AW-1:0];
         w_sel_data = bus.xif_wdata_i;
      end
   end

   // A load response losing to EX is parked; it drains in the first EX-free cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
      end else if (bus.ex_we_i) begin
         if (bus.lsu_we_i) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= bus.lsu_waddr_i[AW-1:0];
            r_buf_data  <= bus.lsu_wdata_i;
         end
      end else if (r_buf_valid) begin
         r_buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_sel != WB_NONE) begin
         r_we    <= (w_sel_addr != '0);
         r_waddr <= 5'(w_sel_addr);
         r_wdata <= w_sel_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   cve2_wb_scoreboard #(
      .AW         (AW),
      .XInterface (XInterface != 0)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .set_i      (bus.sb_set_i),
      .set_addr_i (bus.sb_set_addr_i[AW-1:0]),
      .clr_i      (r_we),
      .clr_addr_i (r_waddr[AW-1:0]),
      .raddr_a_i  (bus.raddr_a_i[AW-1:0]),
      .raddr_b_i  (bus.raddr_b_i[AW-1:0]),
      .raddr_c_i  (bus.raddr_c_i[AW-1:0]),
      .hazard_o   (bus.hazard_o)
   );

   assign bus.lsu_ready_o = !r_buf_valid;
   assign bus.xif_ready_o = w_xif_ready;
   assign bus.we_o        = r_we;
   assign bus.waddr_o     = r_waddr;
   assign bus.wdata_o     = r_wdata;

   lsu_resp_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.lsu_we_i && r_buf_valid));

endmodule
